// File: rtl/uart_tx_shift_engine.sv
// rtl/uart_tx_shift_engine.sv - UART transmit frame builder and LSB-first shifter
// Frames a held byte as start/data/parity/stop bits and shifts it out at a k+1 clock bit period.
module uart_tx_shift_engine #(
  parameter int K_WIDTH = 19
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_load,
  input  logic [7:0]         i_data_in,
  input  logic               i_doit,
  input  logic               i_eight,
  input  logic               i_pen,
  input  logic               i_ohel,
  input  logic [K_WIDTH-1:0] i_k,
  output logic               o_load_d1,
  output logic               o_tx,
  output logic               o_done
);

  logic [7:0]         r_hold;
  logic               r_load_d1;
  logic [10:0]        r_shift;
  logic [K_WIDTH-1:0] r_bt_cnt;
  logic [3:0]         r_bit_cnt;
  logic               r_done;

  logic               w_accept;
  logic               w_btu;
  logic               w_parity;
  logic [1:0]         w_top;
  logic [10:0]        w_frame;

  assign w_accept = i_load && !i_doit;
  assign w_btu    = i_doit && (r_bt_cnt == i_k);

  always_comb begin
    w_parity = (i_eight ? ^r_hold : ^r_hold[6:0]) ^ i_ohel;
    w_top    = 2'b11;
    case ({i_eight, i_pen})
      2'b11:   w_top = {w_parity, r_hold[7]};
      2'b10:   w_top = {1'b1, r_hold[7]};
      2'b01:   w_top = {1'b1, w_parity};
      default: w_top = 2'b11;
    endcase
    w_frame = {w_top, r_hold[6:0], 1'b0, 1'b1};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hold    <= 8'h00;
      r_load_d1 <= 1'b0;
    end else begin
      r_load_d1 <= w_accept;
      if (w_accept) begin
        r_hold <= i_data_in;
      end
    end
  end

  // load_d1 wins over the idle fill so the frame lands before the flag raises doit
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_shift <= 11'h7FF;
    end else if (r_load_d1) begin
      r_shift <= w_frame;
    end else if (!i_doit) begin
      r_shift <= 11'h7FF;
    end else if (w_btu) begin
      r_shift <= {1'b1, r_shift[10:1]};
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_bt_cnt <= '0;
    end else if (!i_doit || w_btu) begin
      r_bt_cnt <= '0;
    end else begin
      r_bt_cnt <= r_bt_cnt + K_WIDTH'(1);
    end
  end

  // bit count saturates at 11 so done fires once per frame even while doit lingers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_bit_cnt <= 4'd0;
      r_done    <= 1'b0;
    end else begin
      r_done <= w_btu && (r_bit_cnt == 4'd10);
      if (!i_doit) begin
        r_bit_cnt <= 4'd0;
      end else if (w_btu && (r_bit_cnt != 4'd11)) begin
        r_bit_cnt <= r_bit_cnt + 4'd1;
      end
    end
  end

  assign o_load_d1 = r_load_d1;
  assign o_tx      = r_shift[0];
  assign o_done    = r_done;

endmodule

// File: tb/tb_uart_tx_shift_engine.sv
// tb/tb_uart_tx_shift_engine.sv - self-checking bench for uart_tx_shift_engine
// Table vectors, hand-written corner sequences and randomized frames against a frame-list model.
module tb_uart_tx_shift_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [7:0]  data_in = 8'h00;
  logic        doit;
  logic        eight = 1'b1;
  logic        pen = 1'b0;
  logic        ohel = 1'b0;
  logic [18:0] k_in = 19'd0;
  logic        load_d1;
  logic        tx;
  logic        done;

  logic        flag;
  logic        kill = 1'b0;
  logic        clr_flag = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0]  d;
    logic        eight;
    logic        pen;
    logic        ohel;
    int          k;
    logic [10:0] frame;
  } vec_t;

  vec_t tbl[5];

  always #5 clk = ~clk;

  uart_tx_shift_engine #(.K_WIDTH(19)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_load    (load),
    .i_data_in (data_in),
    .i_doit    (doit),
    .i_eight   (eight),
    .i_pen     (pen),
    .i_ohel    (ohel),
    .i_k       (k_in),
    .o_load_d1 (load_d1),
    .o_tx      (tx),
    .o_done    (done)
  );

  // upstream doit set/reset flag
  always @(posedge clk or posedge rst) begin
    if (rst)                   flag <= 1'b0;
    else if (clr_flag || done) flag <= 1'b0;
    else if (load_d1)          flag <= 1'b1;
  end
  assign doit = flag & ~kill;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame as the list of line levels in shift order: idle, start, data, parity, then stop fill.
  function automatic logic [10:0] model_frame(input logic [7:0] d, input logic e8,
                                              input logic pe, input logic odd);
    logic q[$];
    logic [10:0] f;
    int nb;
    logic p;
    nb = e8 ? 8 : 7;
    p = odd;
    q.push_back(1'b1);
    q.push_back(1'b0);
    for (int i = 0; i < nb; i++) begin
      q.push_back(d[i]);
      p = p ^ d[i];
    end
    if (pe) q.push_back(p);
    while (q.size() < 11) q.push_back(1'b1);
    for (int i = 0; i < 11; i++) f[i] = q[i];
    return f;
  endfunction

  task automatic send(input logic [7:0] d);
    load = 1'b1;
    data_in = d;
    @(negedge clk);
    load = 1'b0;
    check("load_d1_accept", {31'd0, load_d1}, 32'd1);
  endtask

  task automatic wait_doit(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (doit) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("doit_rise", {31'd0, ok}, 32'd1);
  endtask

  // Entered at the negedge of the first doit cycle (t = 0); returns at t = L+1.
  task automatic watch(input logic [10:0] frame, input int k, input int busy_at);
    int L;
    int tx_errs;
    int first_bad;
    int done_errs;
    int j;
    logic exp_tx;
    L = 11 * (k + 1);
    tx_errs = 0;
    first_bad = -1;
    done_errs = 0;
    for (int t = 0; t <= L + 1; t++) begin
      j = t / (k + 1);
      exp_tx = (j <= 10) ? frame[j] : 1'b1;
      if (tx !== exp_tx) begin
        tx_errs++;
        if (first_bad < 0) first_bad = t;
      end
      if (done !== ((t == L) ? 1'b1 : 1'b0)) done_errs++;
      if (busy_at >= 0 && t == busy_at + 1) begin
        load = 1'b0;
        check("busy_load_ignored", {31'd0, load_d1}, 32'd0);
      end
      if (busy_at >= 0 && t == busy_at) begin
        load = 1'b1;
        data_in = 8'hFF;
      end
      if (t <= L) @(negedge clk);
    end
    if (tx_errs != 0) $display("FAIL tx_seq first bad cycle %0d of frame %0h", first_bad, frame);
    check("tx_seq_errors", tx_errs, 0);
    check("done_pulse_errors", done_errs, 0);
    check("doit_fall", {31'd0, doit}, 32'd0);
  endtask

  task automatic run_frame(input logic [7:0] d, input logic e8, input logic pe,
                           input logic odd, input int k, input logic [10:0] frame,
                           input int busy_at);
    bit ok;
    eight = e8;
    pen = pe;
    ohel = odd;
    k_in = 19'(k);
    send(d);
    wait_doit(ok);
    if (ok) watch(frame, k, busy_at);
  endtask

  initial begin
    bit ok;
    int errs;
    logic [7:0] rd;
    logic re8, rpe, rod;
    int rk;

    tbl[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 3, 11'h695};
    tbl[1] = '{8'h07, 1'b1, 1'b1, 1'b0, 1, 11'h41D};
    tbl[2] = '{8'h07, 1'b1, 1'b1, 1'b1, 1, 11'h01D};
    tbl[3] = '{8'h83, 1'b0, 1'b1, 1'b1, 0, 11'h60D};
    tbl[4] = '{8'h55, 1'b0, 1'b0, 1'b0, 2, 11'h755};

    @(negedge clk);
    check("reset_tx", {31'd0, tx}, 32'd1);
    check("reset_load_d1", {31'd0, load_d1}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      run_frame(tbl[i].d, tbl[i].eight, tbl[i].pen, tbl[i].ohel, tbl[i].k, tbl[i].frame, -1);
    end

    // load during a busy frame and in the done cycle are ignored; load right after doit falls is taken
    run_frame(8'h00, 1'b1, 1'b0, 1'b0, 2, 11'h401, 10);
    run_frame(8'h00, 1'b1, 1'b0, 1'b0, 1, 11'h401, 22);
    run_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1, model_frame(8'h3C, 1'b1, 1'b0, 1'b0), -1);

    // async reset mid-frame
    eight = 1'b1; pen = 1'b0; ohel = 1'b0; k_in = 19'd3;
    send(8'h55);
    wait_doit(ok);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_tx", {31'd0, tx}, 32'd1);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_load_d1", {31'd0, load_d1}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    errs = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || done !== 1'b0) errs++;
    end
    check("post_reset_idle", errs, 0);

    // external doit drop after five bit times
    eight = 1'b1; pen = 1'b1; ohel = 1'b0; k_in = 19'd1;
    send(8'hC3);
    wait_doit(ok);
    repeat (11) @(negedge clk);
    kill = 1'b1;
    clr_flag = 1'b1;
    @(negedge clk);
    check("drop_tx", {31'd0, tx}, 32'd1);
    kill = 1'b0;
    clr_flag = 1'b0;
    errs = 0;
    for (int i = 0; i < 10; i++) begin
      if (tx !== 1'b1 || done !== 1'b0) errs++;
      @(negedge clk);
    end
    check("drop_idle_no_done", errs, 0);
    run_frame(8'hC3, 1'b1, 1'b1, 1'b0, 1, model_frame(8'hC3, 1'b1, 1'b1, 1'b0), -1);

    for (int i = 0; i < 12; i++) begin
      rd  = 8'($urandom);
      re8 = 1'($urandom);
      rpe = 1'($urandom);
      rod = 1'($urandom);
      rk  = int'($urandom_range(0, 3));
      run_frame(rd, re8, rpe, rod, rk, model_frame(rd, re8, rpe, rod), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
